// File: rtl/phy_link_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phy_link_ctrl_pkg
//  Description : Shared definitions for the two-lane phy link controller:
//                FSM state encodings, default comma word and a saturating
//                8-bit increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package phy_link_ctrl_pkg;

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_TRAIN     = 2'd1;
    localparam logic [1:0] c_ST_WAIT_LOCK = 2'd2;
    localparam logic [1:0] c_ST_ACTIVE    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = c_ST_IDLE,
        ST_TRAIN     = c_ST_TRAIN,
        ST_WAIT_LOCK = c_ST_WAIT_LOCK,
        ST_ACTIVE    = c_ST_ACTIVE
    } link_state_e;

    // Idle / training word; phy_tx emits it whenever its valid input is low.
    localparam logic [7:0] c_COMMA_DEFAULT = 8'hBC;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phy_link_ctrl_lane_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : phy_link_ctrl_lane_monitor
//  Description : Per-lane receive monitor. Counts consecutive comma words
//                (lock) while lock counting is enabled and consecutive
//                invalid non-comma words (loss) while loss counting is
//                enabled. o_locked / o_lost reflect the count that this
//                cycle's word produces, so the controller can change state on
//                the same edge the threshold is reached.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_lock_en         - count commas toward lock
//                i_loss_en         - count bad words toward loss
//                i_clear           - zero both counters on this edge
//                i_rx_data/valid   - word received on this lane
//                o_locked / o_lost - threshold reached this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_link_ctrl_lane_monitor
    import phy_link_ctrl_pkg::*;
#(
    parameter logic [7:0] COMMA    = c_COMMA_DEFAULT,
    parameter int         LOCK_CNT = 4,
    parameter int         LOSS_CNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_lock_en,
    input  logic       i_loss_en,
    input  logic       i_clear,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic       o_locked,
    output logic       o_lost
);

    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam int SW = $clog2(LOSS_CNT + 1);

    logic [LW-1:0] r_lock_cnt_q, w_lock_cnt_d, w_lock_next;
    logic [SW-1:0] r_loss_cnt_q, w_loss_cnt_d, w_loss_next;
    logic          w_is_comma;
    logic          w_is_bad;

    assign w_is_comma = !i_rx_valid && (i_rx_data == COMMA);
    assign w_is_bad   = !i_rx_valid && (i_rx_data != COMMA);

    // Counting path kept apart from the clear so the threshold flags never
    // depend on the controller's next-state decision (no combinational loop).
    always_comb begin
        w_lock_next = r_lock_cnt_q;
        w_loss_next = r_loss_cnt_q;
        if (i_lock_en) begin
            if (w_is_comma) begin
                if (r_lock_cnt_q != LW'(LOCK_CNT)) begin
                    w_lock_next = r_lock_cnt_q + LW'(1);
                end
            end else begin
                w_lock_next = '0;
            end
        end
        if (i_loss_en) begin
            if (w_is_bad) begin
                if (r_loss_cnt_q != SW'(LOSS_CNT)) begin
                    w_loss_next = r_loss_cnt_q + SW'(1);
                end
            end else begin
                w_loss_next = '0;
            end
        end
    end

    assign o_locked     = (w_lock_next == LW'(LOCK_CNT));
    assign o_lost       = (w_loss_next == SW'(LOSS_CNT));
    assign w_lock_cnt_d = i_clear ? '0 : w_lock_next;
    assign w_loss_cnt_d = i_clear ? '0 : w_loss_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_cnt_q <= '0;
            r_loss_cnt_q <= '0;
        end else begin
            r_lock_cnt_q <= w_lock_cnt_d;
            r_loss_cnt_q <= w_loss_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/phy_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : phy_link_ctrl
//  Description : Link bring-up and traffic controller for the two-lane phy.
//                Trains with comma words, declares lock when both rx lanes
//                return stable commas, then forwards upstream bytes to
//                phy_tx. Retrains on loss of comma sync or lock timeout.
//  Ports       : clk_2f, reset          - clock, synchronous active-high reset
//                enable                 - link enable (0 forces IDLE)
//                data_in0/1, valid_in0/1 - upstream bytes and qualifiers
//                ready_out              - upstream may transfer
//                tx_data0/1, tx_valid0/1 - to phy_tx
//                rx_data0/1, rx_valid0/1 - from phy_rx
//                link_up, state, retrain_cnt - status
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_link_ctrl
    import phy_link_ctrl_pkg::*;
#(
    parameter logic [7:0] COMMA       = c_COMMA_DEFAULT,
    parameter int         TRAIN_WORDS = 16,
    parameter int         LOCK_CNT    = 4,
    parameter int         TIMEOUT     = 255,
    parameter int         LOSS_CNT    = 3
) (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] data_in0,
    input  logic [7:0] data_in1,
    input  logic       valid_in0,
    input  logic       valid_in1,
    output logic       ready_out,
    output logic [7:0] tx_data0,
    output logic [7:0] tx_data1,
    output logic       tx_valid0,
    output logic       tx_valid1,
    input  logic [7:0] rx_data0,
    input  logic [7:0] rx_data1,
    input  logic       rx_valid0,
    input  logic       rx_valid1,
    output logic       link_up,
    output logic [1:0] state,
    output logic [7:0] retrain_cnt
);

    localparam int TCW = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
    localparam int TOW = $clog2(TIMEOUT + 1);

    link_state_e    r_state_q, w_state_d;
    logic [TCW-1:0] r_train_cnt_q, w_train_cnt_d;
    logic [TOW-1:0] r_timeout_cnt_q, w_timeout_cnt_d;
    logic [7:0]     r_retrain_cnt_q, w_retrain_cnt_d;
    logic [7:0]     r_tx_data0_q, w_tx_data0_d;
    logic [7:0]     r_tx_data1_q, w_tx_data1_d;
    logic           r_tx_valid0_q, w_tx_valid0_d;
    logic           r_tx_valid1_q, w_tx_valid1_d;
    logic           r_link_up_q, w_link_up_d;
    logic           r_ready_q, w_ready_d;

    logic w_fwd;
    logic w_clear;
    logic w_lock_en;
    logic w_loss_en;
    logic w_locked0, w_locked1;
    logic w_lost0, w_lost1;

    assign w_lock_en = (r_state_q == ST_WAIT_LOCK);
    assign w_loss_en = (r_state_q == ST_ACTIVE);
    // Lane counters restart on every state entry.
    assign w_clear   = (w_state_d != r_state_q);

    phy_link_ctrl_lane_monitor #(
        .COMMA    (COMMA),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT)
    ) u_mon0 (
        .clk        (clk_2f),
        .rst        (reset),
        .i_lock_en  (w_lock_en),
        .i_loss_en  (w_loss_en),
        .i_clear    (w_clear),
        .i_rx_data  (rx_data0),
        .i_rx_valid (rx_valid0),
        .o_locked   (w_locked0),
        .o_lost     (w_lost0)
    );

    phy_link_ctrl_lane_monitor #(
        .COMMA    (COMMA),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT)
    ) u_mon1 (
        .clk        (clk_2f),
        .rst        (reset),
        .i_lock_en  (w_lock_en),
        .i_loss_en  (w_loss_en),
        .i_clear    (w_clear),
        .i_rx_data  (rx_data1),
        .i_rx_valid (rx_valid1),
        .o_locked   (w_locked1),
        .o_lost     (w_lost1)
    );

    always_comb begin
        w_state_d       = r_state_q;
        w_train_cnt_d   = r_train_cnt_q;
        w_timeout_cnt_d = r_timeout_cnt_q;
        w_retrain_cnt_d = r_retrain_cnt_q;
        w_fwd           = 1'b0;

        if (!enable) begin
            w_state_d = ST_IDLE;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    w_state_d = ST_TRAIN;
                end
                ST_TRAIN: begin
                    if (r_train_cnt_q == TCW'(TRAIN_WORDS - 1)) begin
                        w_state_d = ST_WAIT_LOCK;
                    end else begin
                        w_train_cnt_d = r_train_cnt_q + TCW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock is tested first so it wins over a same-cycle timeout.
                    if (w_locked0 && w_locked1) begin
                        w_state_d = ST_ACTIVE;
                    end else if (r_timeout_cnt_q == TOW'(TIMEOUT - 1)) begin
                        w_state_d       = ST_TRAIN;
                        w_retrain_cnt_d = sat_inc8(r_retrain_cnt_q);
                    end else begin
                        w_timeout_cnt_d = r_timeout_cnt_q + TOW'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (w_lost0 || w_lost1) begin
                        w_state_d       = ST_TRAIN;
                        w_retrain_cnt_d = sat_inc8(r_retrain_cnt_q);
                    end else begin
                        w_fwd = 1'b1;
                    end
                end
                default: begin
                    w_state_d = ST_IDLE;
                end
            endcase
        end

        if (w_state_d != r_state_q) begin
            w_train_cnt_d   = '0;
            w_timeout_cnt_d = '0;
        end

        // Outputs follow the state being entered, so status changes on the
        // same edge as the state register.
        w_link_up_d   = (w_state_d == ST_ACTIVE);
        w_ready_d     = (w_state_d == ST_ACTIVE);
        w_tx_data0_d  = w_fwd ? data_in0 : COMMA;
        w_tx_data1_d  = w_fwd ? data_in1 : COMMA;
        w_tx_valid0_d = w_fwd && valid_in0;
        w_tx_valid1_d = w_fwd && valid_in1;
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_state_q       <= ST_IDLE;
            r_train_cnt_q   <= '0;
            r_timeout_cnt_q <= '0;
            r_retrain_cnt_q <= 8'h00;
            r_tx_data0_q    <= 8'h00;
            r_tx_data1_q    <= 8'h00;
            r_tx_valid0_q   <= 1'b0;
            r_tx_valid1_q   <= 1'b0;
            r_link_up_q     <= 1'b0;
            r_ready_q       <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_train_cnt_q   <= w_train_cnt_d;
            r_timeout_cnt_q <= w_timeout_cnt_d;
            r_retrain_cnt_q <= w_retrain_cnt_d;
            r_tx_data0_q    <= w_tx_data0_d;
            r_tx_data1_q    <= w_tx_data1_d;
            r_tx_valid0_q   <= w_tx_valid0_d;
            r_tx_valid1_q   <= w_tx_valid1_d;
            r_link_up_q     <= w_link_up_d;
            r_ready_q       <= w_ready_d;
        end
    end

    assign state       = r_state_q;
    assign link_up     = r_link_up_q;
    assign ready_out   = r_ready_q;
    assign retrain_cnt = r_retrain_cnt_q;
    assign tx_data0    = r_tx_data0_q;
    assign tx_data1    = r_tx_data1_q;
    assign tx_valid0   = r_tx_valid0_q;
    assign tx_valid1   = r_tx_valid1_q;

endmodule
`default_nettype wire

// File: tb/tb_phy_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phy_link_ctrl
//  Description : Self-checking bench for phy_link_ctrl. A run-length model of
//                the link rules is compared against the DUT every cycle, and
//                directed scenarios pin the model with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phy_link_ctrl;

    logic       clk_2f = 1'b0;
    logic       reset, enable;
    logic [7:0] data_in0, data_in1;
    logic       valid_in0, valid_in1;
    logic       ready_out;
    logic [7:0] tx_data0, tx_data1;
    logic       tx_valid0, tx_valid1;
    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1;
    logic       link_up;
    logic [1:0] state;
    logic [7:0] retrain_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk_2f = ~clk_2f;

    phy_link_ctrl dut (
        .clk_2f      (clk_2f),
        .reset       (reset),
        .enable      (enable),
        .data_in0    (data_in0),
        .data_in1    (data_in1),
        .valid_in0   (valid_in0),
        .valid_in1   (valid_in1),
        .ready_out   (ready_out),
        .tx_data0    (tx_data0),
        .tx_data1    (tx_data1),
        .tx_valid0   (tx_valid0),
        .tx_valid1   (tx_valid1),
        .rx_data0    (rx_data0),
        .rx_data1    (rx_data1),
        .rx_valid0   (rx_valid0),
        .rx_valid1   (rx_valid1),
        .link_up     (link_up),
        .state       (state),
        .retrain_cnt (retrain_cnt)
    );

    // ------------------------------------------------------------------
    // Model: tracks time spent in the current state and run lengths of
    // comma / bad words per lane since state entry.
    // ------------------------------------------------------------------
    int         m_state, m_phase, m_retrain, m_nxt;
    int         m_crun0, m_crun1, m_brun0, m_brun1;
    int         m_c0, m_c1, m_b0, m_b1;
    bit         m_fwd;
    bit         m_live = 1'b0;
    logic [7:0] m_txd0, m_txd1;
    logic       m_txv0, m_txv1;

    always @(posedge clk_2f) begin
        if (reset) begin
            m_live    = 1'b1;
            m_state   = 0;
            m_phase   = 0;
            m_retrain = 0;
            m_crun0   = 0; m_crun1 = 0; m_brun0 = 0; m_brun1 = 0;
            m_txd0    = 8'h00; m_txd1 = 8'h00;
            m_txv0    = 1'b0;  m_txv1 = 1'b0;
        end else if (m_live) begin
            m_nxt = m_state;
            m_fwd = 1'b0;
            m_c0  = (!rx_valid0 && rx_data0 == 8'hBC) ? m_crun0 + 1 : 0;
            m_c1  = (!rx_valid1 && rx_data1 == 8'hBC) ? m_crun1 + 1 : 0;
            m_b0  = (!rx_valid0 && rx_data0 != 8'hBC) ? m_brun0 + 1 : 0;
            m_b1  = (!rx_valid1 && rx_data1 != 8'hBC) ? m_brun1 + 1 : 0;
            if (!enable) begin
                m_nxt = 0;
            end else if (m_state == 0) begin
                m_nxt = 1;
            end else if (m_state == 1) begin
                if (m_phase + 1 >= 16) m_nxt = 2;
            end else if (m_state == 2) begin
                if (m_c0 >= 4 && m_c1 >= 4) begin
                    m_nxt = 3;
                end else if (m_phase + 1 >= 255) begin
                    m_nxt     = 1;
                    m_retrain = (m_retrain < 255) ? m_retrain + 1 : 255;
                end
            end else begin
                if (m_b0 >= 3 || m_b1 >= 3) begin
                    m_nxt     = 1;
                    m_retrain = (m_retrain < 255) ? m_retrain + 1 : 255;
                end else begin
                    m_fwd = 1'b1;
                end
            end
            if (m_nxt != m_state) begin
                m_phase = 0;
                m_crun0 = 0; m_crun1 = 0; m_brun0 = 0; m_brun1 = 0;
            end else begin
                m_phase = m_phase + 1;
                m_crun0 = (m_state == 2) ? m_c0 : 0;
                m_crun1 = (m_state == 2) ? m_c1 : 0;
                m_brun0 = (m_state == 3) ? m_b0 : 0;
                m_brun1 = (m_state == 3) ? m_b1 : 0;
            end
            m_state = m_nxt;
            m_txd0  = m_fwd ? data_in0 : 8'hBC;
            m_txd1  = m_fwd ? data_in1 : 8'hBC;
            m_txv0  = m_fwd && valid_in0;
            m_txv1  = m_fwd && valid_in1;
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clk_2f) begin
        if (m_live) begin
            checks++;
            if (state !== 2'(m_state) || link_up !== (m_state == 3) ||
                ready_out !== (m_state == 3) || retrain_cnt !== 8'(m_retrain) ||
                tx_data0 !== m_txd0 || tx_valid0 !== m_txv0 ||
                tx_data1 !== m_txd1 || tx_valid1 !== m_txv1) begin
                errors++;
                $display("FAIL cycle_model t=%0t got/exp state %0d/%0d link_up %0b/%0b ready %0b/%0b retrain %0d/%0d tx0 %h,%b/%h,%b tx1 %h,%b/%h,%b",
                         $time, state, m_state, link_up, (m_state == 3), ready_out,
                         (m_state == 3), retrain_cnt, m_retrain, tx_data0, tx_valid0,
                         m_txd0, m_txv0, tx_data1, tx_valid1, m_txd1, m_txv1);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_2f);
    endtask

    task automatic wait_up(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_2f);
            if (link_up === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    logic [7:0] v_d0 [3] = '{8'hA5, 8'h3C, 8'h00};
    logic       v_v0 [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] v_d1 [3] = '{8'h00, 8'h5A, 8'hFF};
    logic       v_v1 [3] = '{1'b0, 1'b1, 1'b1};

    bit ok;

    initial begin
        reset = 1'b1; enable = 1'b0;
        data_in0 = 8'h00; data_in1 = 8'h00; valid_in0 = 1'b0; valid_in1 = 1'b0;
        rx_data0 = 8'hBC; rx_data1 = 8'hBC; rx_valid0 = 1'b0; rx_valid1 = 1'b0;
        cyc(2);
        chk("rst_state", 32'(state), 0);
        chk("rst_tx_data0", 32'(tx_data0), 32'h00);
        chk("rst_tx_valid0", 32'(tx_valid0), 0);
        chk("rst_ready", 32'(ready_out), 0);
        chk("rst_link_up", 32'(link_up), 0);
        chk("rst_retrain", 32'(retrain_cnt), 0);
        reset = 1'b0;
        cyc(1);
        chk("idle_state", 32'(state), 0);

        // Bring-up: 16 TRAIN cycles, lock after 4 commas, up on edge 21.
        enable = 1'b1;
        cyc(1);
        chk("train_entry", 32'(state), 1);
        cyc(19);
        chk("edge20_state", 32'(state), 2);
        chk("edge20_link_up", 32'(link_up), 0);
        cyc(1);
        chk("edge21_state", 32'(state), 3);
        chk("edge21_link_up", 32'(link_up), 1);
        chk("edge21_ready", 32'(ready_out), 1);
        chk("edge21_retrain", 32'(retrain_cnt), 0);

        // Forwarding, one-cycle latency, lanes independent.
        for (int i = 0; i < 3; i++) begin
            data_in0 = v_d0[i]; valid_in0 = v_v0[i];
            data_in1 = v_d1[i]; valid_in1 = v_v1[i];
            cyc(1);
            chk("fwd_tx_data0", 32'(tx_data0), 32'(v_d0[i]));
            chk("fwd_tx_valid0", 32'(tx_valid0), 32'(v_v0[i]));
            chk("fwd_tx_data1", 32'(tx_data1), 32'(v_d1[i]));
            chk("fwd_tx_valid1", 32'(tx_valid1), 32'(v_v1[i]));
        end
        valid_in0 = 1'b0; valid_in1 = 1'b0;

        // Two bad words then a comma: link stays up.
        rx_data1 = 8'h3C;
        cyc(2);
        rx_data1 = 8'hBC;
        cyc(1);
        chk("two_bad_stay", 32'(state), 3);
        cyc(1);
        // Three bad words: retrain, beat on that edge dropped.
        rx_data1 = 8'h3C; data_in0 = 8'h77; valid_in0 = 1'b1;
        cyc(2);
        chk("loss_pre_state", 32'(state), 3);
        chk("loss_pre_txv0", 32'(tx_valid0), 1);
        cyc(1);
        chk("loss_state", 32'(state), 1);
        chk("loss_link_up", 32'(link_up), 0);
        chk("loss_ready", 32'(ready_out), 0);
        chk("loss_txv0", 32'(tx_valid0), 0);
        chk("loss_retrain", 32'(retrain_cnt), 1);
        rx_data1 = 8'hBC; valid_in0 = 1'b0;

        // Lane 0 never returns comma: WAIT_LOCK times out after 255 cycles.
        wait_up(40, ok);
        chk("relock_up", 32'(link_up), 1);
        rx_data0 = 8'h11;
        cyc(3);
        chk("lane0_loss_state", 32'(state), 1);
        chk("lane0_loss_retrain", 32'(retrain_cnt), 2);
        cyc(16);
        chk("to_wait_state", 32'(state), 2);
        cyc(254);
        chk("pre_timeout_state", 32'(state), 2);
        cyc(1);
        chk("timeout_state", 32'(state), 1);
        chk("timeout_retrain", 32'(retrain_cnt), 3);

        // Lock completes on the very cycle the timeout would fire: lock wins.
        cyc(267);
        rx_data0 = 8'hBC;
        cyc(3);
        chk("lockwin_pre_state", 32'(state), 2);
        cyc(1);
        chk("lockwin_state", 32'(state), 3);
        chk("lockwin_retrain", 32'(retrain_cnt), 3);

        // Reset asserted in WAIT_LOCK.
        rx_data1 = 8'h3C;
        cyc(3);
        chk("loss2_retrain", 32'(retrain_cnt), 4);
        rx_data1 = 8'hBC;
        cyc(17);
        chk("wl_before_reset", 32'(state), 2);
        reset = 1'b1;
        cyc(1);
        chk("midrst_state", 32'(state), 0);
        chk("midrst_retrain", 32'(retrain_cnt), 0);
        chk("midrst_tx_data0", 32'(tx_data0), 32'h00);
        chk("midrst_tx_data1", 32'(tx_data1), 32'h00);
        chk("midrst_link_up", 32'(link_up), 0);
        reset = 1'b0;
        cyc(1);
        chk("post_rst_train", 32'(state), 1);

        // enable=0 while ACTIVE.
        wait_up(40, ok);
        chk("up_before_disable", 32'(link_up), 1);
        data_in0 = 8'hC3; valid_in0 = 1'b1; enable = 1'b0;
        cyc(1);
        chk("dis_state", 32'(state), 0);
        chk("dis_link_up", 32'(link_up), 0);
        chk("dis_ready", 32'(ready_out), 0);
        chk("dis_txv0", 32'(tx_valid0), 0);
        chk("dis_tx_data0", 32'(tx_data0), 32'hBC);
        valid_in0 = 1'b0;

        // Retrain counter saturation.
        enable = 1'b1;
        for (int i = 0; i < 260; i++) begin
            wait_up(40, ok);
            if (!ok) begin
                chk("sat_wait_up", 32'(link_up), 1);
                break;
            end
            rx_data1 = 8'h3C;
            cyc(3);
            rx_data1 = 8'hBC;
            if (i == 253) chk("sat_254", 32'(retrain_cnt), 32'hFE);
        end
        chk("sat_ff", 32'(retrain_cnt), 32'hFF);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog expired at t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
